// File: rtl/parity_stream_engine_if.sv
// parity_stream_engine_if: input/output stream, parity control and error-stat signals of parity_stream_engine
interface parity_stream_engine_if #(parameter int DATA_W = 8, parameter int CNT_W = 16);
  logic [1:0] parity_type;
  logic s_valid;
  logic s_ready;
  logic [DATA_W-1:0] s_data;
  logic s_parity;
  logic m_valid;
  logic m_ready;
  logic [DATA_W-1:0] m_data;
  logic m_parity;
  logic m_err;
  logic err_sticky;
  logic [CNT_W-1:0] err_count;
  logic clr_err;
  modport master (
    output parity_type, s_valid, s_data, s_parity, m_ready, clr_err,
    input s_ready, m_valid, m_data, m_parity, m_err, err_sticky, err_count
  );
  modport slave (
    input parity_type, s_valid, s_data, s_parity, m_ready, clr_err,
    output s_ready, m_valid, m_data, m_parity, m_err, err_sticky, err_count
  );
endinterface

// File: rtl/parity_stream_engine.sv
// parity_stream_engine: 1-stage parity generate/check with valid/ready; error stats only when PARITY_ERR_STATS_EN is defined
module parity_stream_engine #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  parity_stream_engine_if.slave bus
);
  logic w_accept, w_xor, w_par, w_err;
  logic r_valid, r_parity, r_err;
  logic [DATA_W-1:0] r_data;
  assign bus.s_ready = ~reset & (~r_valid | bus.m_ready);
  assign w_accept = bus.s_valid & bus.s_ready;
  assign w_xor = ^bus.s_data;
  assign w_par = bus.parity_type == 2'b01 ? ~w_xor : bus.parity_type == 2'b10 ? w_xor : 1'b1;
  assign w_err = bus.parity_type != 2'b00 && bus.s_parity != w_par;
  always_ff @(posedge clk)
    if (reset) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_parity <= 1'b1;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data <= bus.s_data;
      r_parity <= w_par;
      r_err <= w_err;
    end else if (bus.m_ready) begin
      r_valid <= 1'b0;
    end
  assign bus.m_valid = r_valid;
  assign bus.m_data = r_data;
  assign bus.m_parity = r_parity;
  assign bus.m_err = r_err;
`ifdef PARITY_ERR_STATS_EN
  logic [CNT_W-1:0] r_cnt, w_cnt_base;
  logic r_sticky, w_sticky_base;
  // clear is folded in before the new error so a simultaneous error counts as 1
  assign w_cnt_base = bus.clr_err ? '0 : r_cnt;
  assign w_sticky_base = bus.clr_err ? 1'b0 : r_sticky;
  always_ff @(posedge clk)
    if (reset) begin
      r_cnt <= '0;
      r_sticky <= 1'b0;
    end else if (w_accept && w_err) begin
      r_cnt <= &w_cnt_base ? w_cnt_base : w_cnt_base + 1'b1;
      r_sticky <= 1'b1;
    end else begin
      r_cnt <= w_cnt_base;
      r_sticky <= w_sticky_base;
    end
  assign bus.err_count = r_cnt;
  assign bus.err_sticky = r_sticky;
`else
  logic w_unused_clr;
  assign w_unused_clr = bus.clr_err;
  assign bus.err_count = '0;
  assign bus.err_sticky = 1'b0;
`endif
endmodule
